// File: rtl/ooo_types.sv
// Shared types and sizing for the out-of-order core's reorder buffer path.
// Tag 0 is reserved as "no dependency" and is never allocated.
package ooo_types;

  localparam int NUM_ROB    = 7;
  localparam int NUM_ALU_RS = 5;
  localparam int TAG_W      = 3;
  localparam int CNT_W      = $clog2(NUM_ROB + 1);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic [NUM_ALU_RS-1:0]       valid;
    logic [NUM_ALU_RS-1:0][31:0] vals;
    tag_t [NUM_ALU_RS-1:0]       tags;
  } alu_cdb_t;

  // Index 0 is reserved and always reads as not-ready / zero
  typedef struct packed {
    logic [NUM_ROB:0]       ready;
    logic [NUM_ROB:0][31:0] vals;
  } rob_out_t;

  // Circular tag increment over 1..NUM_ROB
  function automatic tag_t tag_inc(tag_t t);
    return (t == tag_t'(NUM_ROB)) ? tag_t'(1) : t + tag_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder / ALU-result / regfile-side signal bundle of the reorder buffer.
// slave is the buffer itself, master is whoever drives it.
interface reorder_buffer_if
  import ooo_types::*;
();

  logic       flush;
  logic       alloc_req;
  logic [4:0] alloc_rd;
  logic       alloc_ready;
  tag_t       alloc_tag;
  alu_cdb_t   alu_res;
  rob_out_t   rob_data;
  logic       commit_valid;
  logic [4:0] commit_rd;
  logic [31:0] commit_val;
  tag_t       commit_tag;
  logic       rob_empty;

  modport master (
    output flush, alloc_req, alloc_rd, alu_res,
    input  alloc_ready, alloc_tag, rob_data,
    input  commit_valid, commit_rd, commit_val, commit_tag, rob_empty
  );

  modport slave (
    input  flush, alloc_req, alloc_rd, alu_res,
    output alloc_ready, alloc_tag, rob_data,
    output commit_valid, commit_rd, commit_val, commit_tag, rob_empty
  );

endinterface

// File: rtl/rob_circ_ptr.sv
// Circular tag pointer over 1..NUM_ROB with increment enable.
// Synchronous clear and asynchronous reset both return it to 1.
module rob_circ_ptr
  import ooo_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output tag_t ptr
);

  tag_t ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= tag_t'(1);
    end else if (clr) begin
      ptr_reg <= tag_t'(1);
    end else if (inc) begin
      ptr_reg <= tag_inc(ptr_reg);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer: hands out tags, captures ALU lane results,
// publishes ready/value per tag and retires one entry per cycle in order.
module reorder_buffer
  import ooo_types::*;
(
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob
);

  logic        busy_reg [0:NUM_ROB];
  logic        done_reg [0:NUM_ROB];
  logic [4:0]  rd_reg   [0:NUM_ROB];
  logic [31:0] val_reg  [0:NUM_ROB];
  logic [CNT_W-1:0] count_reg;

  logic        commit_valid_reg;
  logic [4:0]  commit_rd_reg;
  logic [31:0] commit_val_reg;
  tag_t        commit_tag_reg;

  tag_t head;
  tag_t tail;
  logic alloc_fire;
  logic commit_fire;

  logic [NUM_ROB:0] wb_hit;
  logic [31:0]      wb_val [0:NUM_ROB];
  rob_out_t         rob_out;

  assign rob.alloc_ready = (count_reg < CNT_W'(NUM_ROB));
  assign rob.alloc_tag   = tail;
  assign rob.rob_empty   = (count_reg == '0);

  assign alloc_fire  = rob.alloc_req && rob.alloc_ready;
  assign commit_fire = busy_reg[head] && done_reg[head];

  rob_circ_ptr u_head (
    .clk (clk),
    .rst (rst),
    .clr (rob.flush),
    .inc (commit_fire),
    .ptr (head)
  );

  rob_circ_ptr u_tail (
    .clk (clk),
    .rst (rst),
    .clr (rob.flush),
    .inc (alloc_fire),
    .ptr (tail)
  );

  // Per-slot writeback select; scanning lanes high-to-low lets the lowest lane win
  for (genvar gi = 0; gi <= NUM_ROB; gi++) begin : g_wb
    logic        hit;
    logic [31:0] val;
    always_comb begin
      hit = 1'b0;
      val = '0;
      for (int l = NUM_ALU_RS - 1; l >= 0; l--) begin
        if (rob.alu_res.valid[l] && (rob.alu_res.tags[l] == tag_t'(gi)) &&
            (rob.alu_res.tags[l] != '0)) begin
          hit = 1'b1;
          val = rob.alu_res.vals[l];
        end
      end
    end
    assign wb_hit[gi] = hit && busy_reg[gi];
    assign wb_val[gi] = val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t <= NUM_ROB; t++) begin
        busy_reg[t] <= 1'b0;
        done_reg[t] <= 1'b0;
        rd_reg[t]   <= '0;
        val_reg[t]  <= '0;
      end
    end else if (rob.flush) begin
      // Values survive a flush so stale tags still read something coherent
      for (int t = 0; t <= NUM_ROB; t++) begin
        busy_reg[t] <= 1'b0;
        done_reg[t] <= 1'b0;
        rd_reg[t]   <= '0;
      end
    end else begin
      for (int t = 1; t <= NUM_ROB; t++) begin
        if (alloc_fire && (tail == tag_t'(t))) begin
          busy_reg[t] <= 1'b1;
          done_reg[t] <= 1'b0;
          rd_reg[t]   <= rob.alloc_rd;
          val_reg[t]  <= '0;
        end else begin
          if (wb_hit[t]) begin
            done_reg[t] <= 1'b1;
            val_reg[t]  <= wb_val[t];
          end
          if (commit_fire && (head == tag_t'(t))) begin
            busy_reg[t] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (rob.flush) begin
      count_reg <= '0;
    end else begin
      case ({alloc_fire, commit_fire})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid_reg <= 1'b0;
      commit_rd_reg    <= '0;
      commit_val_reg   <= '0;
      commit_tag_reg   <= '0;
    end else if (rob.flush) begin
      commit_valid_reg <= 1'b0;
    end else if (commit_fire) begin
      commit_valid_reg <= 1'b1;
      commit_rd_reg    <= rd_reg[head];
      commit_val_reg   <= val_reg[head];
      commit_tag_reg   <= head;
    end else begin
      commit_valid_reg <= 1'b0;
    end
  end

  always_comb begin
    rob_out = '0;
    for (int t = 1; t <= NUM_ROB; t++) begin
      rob_out.ready[t] = done_reg[t];
      rob_out.vals[t]  = val_reg[t];
    end
  end

  assign rob.rob_data     = rob_out;
  assign rob.commit_valid = commit_valid_reg;
  assign rob.commit_rd    = commit_rd_reg;
  assign rob.commit_val   = commit_val_reg;
  assign rob.commit_tag   = commit_tag_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: queue-based program-order model,
// directed scenarios followed by randomized traffic.
module tb_reorder_buffer;
  import ooo_types::*;

  logic clk;
  logic rst;

  reorder_buffer_if ifc ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rob (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    tag_t       tag;
    logic [4:0] rd;
  } ent_t;

  typedef struct {
    tag_t        tag;
    logic [4:0]  rd;
    logic [31:0] val;
  } cmt_t;

  ent_t        mq [$];
  cmt_t        exp_q [$];
  logic        m_busy [0:NUM_ROB];
  logic        m_done [0:NUM_ROB];
  logic [31:0] m_val  [0:NUM_ROB];
  int          m_tail;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    exp_q.delete();
    for (int t = 0; t <= NUM_ROB; t++) begin
      m_busy[t] = 1'b0;
      m_done[t] = 1'b0;
      m_val[t]  = '0;
    end
    m_tail = 1;
  endfunction

  // Reference model: the ROB is a FIFO of outstanding instructions in program order
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else if (ifc.flush) begin
      mq.delete();
      for (int t = 0; t <= NUM_ROB; t++) begin
        m_busy[t] = 1'b0;
        m_done[t] = 1'b0;
      end
      m_tail = 1;
    end else begin
      int   n0;
      logic do_commit;
      logic do_alloc;
      logic claimed [0:NUM_ROB];
      n0 = mq.size();
      do_commit = (n0 > 0) && m_done[mq[0].tag];
      do_alloc  = ifc.alloc_req && (n0 < NUM_ROB);
      if (do_commit) begin
        cmt_t c;
        c.tag = mq[0].tag;
        c.rd  = mq[0].rd;
        c.val = m_val[mq[0].tag];
        exp_q.push_back(c);
      end
      for (int t = 0; t <= NUM_ROB; t++) claimed[t] = 1'b0;
      for (int l = 0; l < NUM_ALU_RS; l++) begin
        int tg;
        tg = int'(ifc.alu_res.tags[l]);
        if (ifc.alu_res.valid[l] && tg != 0 && m_busy[tg] && !claimed[tg]) begin
          claimed[tg] = 1'b1;
          m_done[tg]  = 1'b1;
          m_val[tg]   = ifc.alu_res.vals[l];
        end
      end
      if (do_commit) begin
        m_busy[mq[0].tag] = 1'b0;
        void'(mq.pop_front());
      end
      if (do_alloc) begin
        ent_t e;
        e.tag = tag_t'(m_tail);
        e.rd  = ifc.alloc_rd;
        mq.push_back(e);
        m_busy[m_tail] = 1'b1;
        m_done[m_tail] = 1'b0;
        m_val[m_tail]  = '0;
        m_tail = (m_tail == NUM_ROB) ? 1 : m_tail + 1;
      end
    end
  end

  // Monitor: compares DUT against the model just after every active edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (ifc.commit_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_commit", 32'(ifc.commit_valid), 32'd0);
        end else begin
          cmt_t c;
          c = exp_q.pop_front();
          $display("[TB] commit tag=%0d rd=%0d val=%08h", ifc.commit_tag, ifc.commit_rd, ifc.commit_val);
          chk("commit_tag", 32'(ifc.commit_tag), 32'(c.tag));
          chk("commit_rd",  32'(ifc.commit_rd),  32'(c.rd));
          chk("commit_val", ifc.commit_val, c.val);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_commit", 32'(ifc.commit_valid), 32'd1);
        exp_q.delete();
      end
      chk("alloc_ready", 32'(ifc.alloc_ready), 32'(mq.size() < NUM_ROB));
      chk("rob_empty",   32'(ifc.rob_empty),   32'(mq.size() == 0));
      chk("alloc_tag",   32'(ifc.alloc_tag),   32'(m_tail));
      for (int t = 0; t <= NUM_ROB; t++) begin
        chk($sformatf("ready[%0d]", t), 32'(ifc.rob_data.ready[t]), (t == 0) ? 32'd0 : 32'(m_done[t]));
        chk($sformatf("vals[%0d]", t), ifc.rob_data.vals[t], (t == 0) ? 32'd0 : m_val[t]);
      end
    end
  end

  task automatic idle();
    ifc.flush     = 1'b0;
    ifc.alloc_req = 1'b0;
    ifc.alloc_rd  = '0;
    ifc.alu_res   = '0;
  endtask

  task automatic wb(int lane, int tag, logic [31:0] v);
    ifc.alu_res.valid[lane] = 1'b1;
    ifc.alu_res.tags[lane]  = tag_t'(tag);
    ifc.alu_res.vals[lane]  = v;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_commit_valid", 32'(ifc.commit_valid), 32'd0);
    chk("rst_commit_rd",    32'(ifc.commit_rd),    32'd0);
    chk("rst_commit_val",   ifc.commit_val,        32'd0);
    chk("rst_alloc_ready",  32'(ifc.alloc_ready),  32'd1);
    chk("rst_alloc_tag",    32'(ifc.alloc_tag),    32'd1);
    chk("rst_rob_empty",    32'(ifc.rob_empty),    32'd1);

    // Three allocations rd=5,6,7
    for (int i = 0; i < 3; i++) begin
      ifc.alloc_req = 1'b1;
      ifc.alloc_rd  = 5'(5 + i);
      #1 chk("t1_alloc_tag", 32'(ifc.alloc_tag), 32'(i + 1));
      @(negedge clk);
    end
    idle();
    #1 chk("t1_not_empty", 32'(ifc.rob_empty), 32'd0);

    // Writeback tag1 on lane 2, then a commit pulse one cycle later
    wb(2, 1, 32'hDEAD);
    @(negedge clk);
    idle();
    #1;
    chk("t2_ready1",  32'(ifc.rob_data.ready[1]), 32'd1);
    chk("t2_no_pulse_yet", 32'(ifc.commit_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("t2_commit_valid", 32'(ifc.commit_valid), 32'd1);
    chk("t2_commit_rd",    32'(ifc.commit_rd),    32'd5);
    chk("t2_commit_val",   ifc.commit_val,        32'hDEAD);
    chk("t2_commit_tag",   32'(ifc.commit_tag),   32'd1);

    // Out-of-order completion: tag3 first blocks until tag2 completes
    @(negedge clk);
    wb(0, 3, 32'h3333);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1 chk("t3_blocked", 32'(ifc.commit_valid), 32'd0);
    wb(1, 2, 32'h2222);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);

    // Fill all seven slots starting at tag 4, then try one more
    for (int i = 0; i < NUM_ROB; i++) begin
      ifc.alloc_req = 1'b1;
      ifc.alloc_rd  = 5'(10 + i);
      @(negedge clk);
    end
    #1 chk("t4_full", 32'(ifc.alloc_ready), 32'd0);
    ifc.alloc_rd = 5'd31;
    @(negedge clk);
    #1 chk("t4_tag_held", 32'(ifc.alloc_tag), 32'd4);
    // Complete the two oldest; alloc stays requested throughout
    wb(0, 4, 32'h4444);
    wb(1, 5, 32'h5555);
    @(negedge clk);
    ifc.alu_res = '0;
    @(negedge clk);
    #1;
    chk("t4_reopen", 32'(ifc.alloc_ready), 32'd1);
    chk("t4_wrap_tag", 32'(ifc.alloc_tag), 32'd4);
    @(negedge clk);
    idle();
    #1 chk("t4_alloc_commit_same", 32'(ifc.alloc_ready), 32'd1);

    // Writes to a non-busy tag and to tag 0 are dropped; lowest lane wins
    wb(0, 5, 32'hBAD0);
    wb(1, 0, 32'hBAD1);
    wb(0 + 3, 2, 32'hB0B3);
    wb(4, 2, 32'hB0B4);
    ifc.alu_res.valid[2] = 1'b1;
    ifc.alu_res.tags[2]  = tag_t'(2);
    ifc.alu_res.vals[2]  = 32'hB0B2;
    @(negedge clk);
    idle();
    #1;
    chk("t5_nonbusy_kept", ifc.rob_data.vals[5], 32'h5555);
    chk("t5_lowest_lane",  ifc.rob_data.vals[2], 32'hB0B2);
    chk("t5_tag0_vals",    ifc.rob_data.vals[0], 32'd0);

    // Complete the head, then flush on the cycle it would have retired
    wb(0, 6, 32'h6666);
    @(negedge clk);
    idle();
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    #1;
    chk("t6_no_commit", 32'(ifc.commit_valid), 32'd0);
    chk("t6_empty",     32'(ifc.rob_empty),    32'd1);
    chk("t6_tag1",      32'(ifc.alloc_tag),    32'd1);
    chk("t6_ready_all", 32'(ifc.rob_data.ready), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      ifc.alloc_req = ($urandom_range(0, 9) < 6);
      ifc.alloc_rd  = 5'($urandom);
      for (int l = 0; l < NUM_ALU_RS; l++) begin
        if ($urandom_range(0, 3) == 0) wb(l, int'($urandom_range(0, NUM_ROB)), $urandom);
      end
      ifc.flush = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    idle();

    // Build up some state, then an asynchronous reset pulse mid-cycle
    for (int i = 0; i < 3; i++) begin
      ifc.alloc_req = 1'b1;
      ifc.alloc_rd  = 5'(i + 1);
      wb(0, int'(ifc.alloc_tag) == 1 ? NUM_ROB : int'(ifc.alloc_tag) - 1, 32'hA5A5);
      @(negedge clk);
    end
    idle();
    wb(0, int'(ifc.alloc_tag) == 1 ? NUM_ROB : int'(ifc.alloc_tag) - 1, 32'h1234);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_commit_valid", 32'(ifc.commit_valid), 32'd0);
    chk("arst_commit_val",   ifc.commit_val,         32'd0);
    chk("arst_empty",        32'(ifc.rob_empty),     32'd1);
    chk("arst_alloc_tag",    32'(ifc.alloc_tag),     32'd1);
    chk("arst_ready",        32'(ifc.rob_data.ready), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
